bus_copy_engine: RTL and testbench
==================================

// Module: bus_copy_engine
// PURPOSE
//  Bus initiator for the 8-bit femto8 memory bus: the other end of the RAM/ROM/IO
//  decode that answers the CPU. Copies a block of bytes from src to dst over the
//  same address/data/write signalling (combinational read data, write on posedge).
//  Sits beside the CPU behind a bus mux and owns the bus only while bus_grant=1.
//  Lets the game logic bulk-load sprite/RAM tables without CPU loops.
// PARAMETERS
//  ADDR_W   8  bus address width; pointer arithmetic wraps modulo 2**ADDR_W
//  DATA_W   8  bus data width
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse: launch copy (ignored while busy=1)
//  src_addr     in   ADDR_W  first source address, sampled on start
//  dst_addr     in   ADDR_W  first destination address, sampled on start
//  count        in   8       bytes to copy, sampled on start; 0 = no transfer
//  busy         out  1       1 from cycle after accepted start until done
//  done         out  1       1-cycle pulse when transfer completes
//  bus_req      out  1       request bus ownership from the mux
//  bus_grant    in   1       mux grants bus; may drop at any cycle
//  address      out  ADDR_W  bus address (0 when not owning bus)
//  data_in      in   DATA_W  read data from responder, valid same cycle as address
//  data_out     out  DATA_W  write data to responder
//  write        out  1       bus write enable; only ever 1 in WRITE with grant=1
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; busy=0, done=0, bus_req=0, address=0,
//   data_out=0, write=0; pointers, remaining count, latch cleared. Reset mid-copy
//   aborts at once; no partial write is completed and no done pulse is issued.
//  States: IDLE -> REQ -> READ <-> WRITE -> DONE -> IDLE.
//  IDLE: on start: sample src/dst/count; count==0 -> DONE directly (no bus_req,
//   no bus cycle, done pulse next cycle); else -> REQ, busy=1.
//  REQ: bus_req=1; on bus_grant=1 -> READ (next cycle).
//  READ: address=src ptr, write=0; data_in latched at posedge; src ptr+1 -> WRITE.
//  WRITE: address=dst ptr, data_out=latch, write=1; dst ptr+1, remaining-1;
//   remaining reaches 0 -> DONE, else -> READ. One byte every 2 clocks.
//  Grant loss: bus_grant sampled each READ/WRITE cycle; if 0 the cycle is
//   not performed (address=0, write=0), pointers/latch hold, -> REQ. Resume
//   re-enters the state that was interrupted (READ or WRITE), never repeats
//   or skips a byte.
//  DONE: bus_req=0, done=1 for exactly one cycle, busy=0 from that cycle; -> IDLE.
//  bus_req stays 1 from REQ through the last WRITE (no release between bytes).
//  Pointer wrap: 0xFF+1 = 0x00 on either pointer; overlapping src/dst copies
//   forward byte-by-byte (no memmove semantics).
//  start while busy: ignored, no effect on in-flight copy.
//  start same cycle as done: accepted only from IDLE, i.e. one cycle later.
// CONFIGURATION
//  BUS_COPY_FILL_EN defined: extra ports fill (in,1) and fill_value (in,DATA_W),
//   sampled on start; fill=1 skips READ, each byte is a WRITE of fill_value,
//   one byte per clock. fill=0 behaves as plain copy.
//  Not defined: ports absent, copy only; no fill logic synthesised.
// STRUCTURE
//  Shared package: state encoding constants (IDLE/REQ/READ/WRITE/DONE), bus
//   width constants ADDR_W/DATA_W shared with the memory decode.
//  One sub-module: bus_copy_ptr (loadable up-counter with wrap, used for src,
//   dst; down-count variant for remaining).
// TESTING
//  Bench models bus as 256-byte RAM with combinational read, posedge write.
//  1 copy src=0x80 dst=0x10 count=4, grant tied 1 -> RAM[0x10..0x13]=RAM[0x80..0x83],
//    done pulses once, exactly 4 write cycles, busy=1 for 9 cycles.
//  2 count=0 start -> done 1 cycle later, bus_req never 1, no writes.
//  3 src=0xFE dst=0xFF count=3 -> reads 0xFE,0xFF,0x00; writes 0xFF,0x00,0x01.
//  4 grant dropped 3 cycles during 2nd READ then restored -> write/address=0
//    while ungranted, final RAM identical to test 1, no duplicate writes.
//  5 reset low mid-WRITE of byte 2 of 4 -> outputs 0 immediately, only byte 1
//    written, no done; start after release copies normally.
//  6 FILL_EN: fill=1 fill_value=0xA5 dst=0x20 count=3 -> RAM[0x20..0x22]=0xA5,
//    3 consecutive write cycles, no reads; start during busy ignored.

Source files
------------

// File: rtl/bus_copy_engine_pkg.sv
// Shared definitions for the femto8 bus copy engine.
//   BUS_ADDR_W / BUS_DATA_W : bus widths shared with the memory decode
//   COUNT_W                 : width of the transfer length
//   state_e                 : copy engine state encoding
package bus_copy_engine_pkg;

    localparam int unsigned BUS_ADDR_W = 8;
    localparam int unsigned BUS_DATA_W = 8;
    localparam int unsigned COUNT_W    = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StRead  = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } state_e;

endpackage

// File: rtl/bus_copy_ptr.sv
// Loadable wrapping counter used for the source/destination pointers (up) and
// the remaining byte count (down). Wraps modulo 2**W.
//   clk        : clock
//   reset      : asynchronous active-low reset, clears the value
//   load       : load load_value (has priority over step)
//   load_value : value to load
//   step       : advance by one (up or down per DOWN)
//   value      : current value
module bus_copy_ptr #(
    parameter int unsigned W    = 8,
    parameter bit          DOWN = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         step,
    output logic [W-1:0] value
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else if (step) begin
            value_d = DOWN ? (value_q - W'(1)) : (value_q + W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/bus_copy_engine.sv
// Bus initiator that copies a block of bytes from src_addr to dst_addr over the
// femto8 memory bus (combinational read data, write on posedge). Owns the bus
// only while bus_grant=1; an ungranted READ/WRITE cycle is skipped and resumed.
// Optional feature macro: BUS_COPY_FILL_EN adds fill/fill_value (block fill).
//   clk, reset          : clock, asynchronous active-low reset
//   start               : launch pulse (ignored unless idle)
//   src_addr, dst_addr  : first source / destination address, sampled on start
//   count               : bytes to copy, 0 = no transfer
//   busy, done          : transfer in progress / one-cycle completion pulse
//   bus_req, bus_grant  : bus ownership handshake with the mux
//   address, data_in    : bus address / combinational read data
//   data_out, write     : bus write data / write enable
//   fill, fill_value    : (BUS_COPY_FILL_EN) write fill_value instead of copying
module bus_copy_engine
    import bus_copy_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = BUS_ADDR_W,
    parameter int unsigned DATA_W = BUS_DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  src_addr,
    input  logic [ADDR_W-1:0]  dst_addr,
    input  logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               done,
    output logic               bus_req,
    input  logic               bus_grant,
    output logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  data_out,
    output logic               write
`ifdef BUS_COPY_FILL_EN
    ,
    input  logic               fill,
    input  logic [DATA_W-1:0]  fill_value
`endif
);

    state_e state_q, state_d;
    // State to return to once the grant comes back (READ or WRITE).
    state_e resume_q, resume_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]  src_ptr, dst_ptr;
    logic [COUNT_W-1:0] remaining;
    logic accept, rd_fire, wr_fire, last;
    logic fill_start, fill_mode;

`ifdef BUS_COPY_FILL_EN
    logic fill_q, fill_d;
    assign fill_start = fill;
    assign fill_mode  = fill_q;
    always_comb begin
        fill_d = fill_q;
        if (accept) fill_d = fill;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end
`else
    assign fill_start = 1'b0;
    assign fill_mode  = 1'b0;
`endif

    assign accept  = (state_q == StIdle) && start;
    assign rd_fire = (state_q == StRead) && bus_grant;
    assign wr_fire = (state_q == StWrite) && bus_grant;
    assign last    = (remaining == COUNT_W'(1));

    bus_copy_ptr #(.W(ADDR_W), .DOWN(1'b0)) u_src_ptr (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (src_addr),
        .step       (rd_fire),
        .value      (src_ptr)
    );

    bus_copy_ptr #(.W(ADDR_W), .DOWN(1'b0)) u_dst_ptr (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (dst_addr),
        .step       (wr_fire),
        .value      (dst_ptr)
    );

    bus_copy_ptr #(.W(COUNT_W), .DOWN(1'b1)) u_remaining (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_value (count),
        .step       (wr_fire),
        .value      (remaining)
    );

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        data_d   = data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = (count == '0) ? StDone : StReq;
                    resume_d = fill_start ? StWrite : StRead;
`ifdef BUS_COPY_FILL_EN
                    if (fill) data_d = fill_value;
`endif
                end
            end
            StReq: begin
                if (bus_grant) state_d = resume_q;
            end
            StRead: begin
                if (bus_grant) begin
                    data_d  = data_in;
                    state_d = StWrite;
                end else begin
                    state_d  = StReq;
                    resume_d = StRead;
                end
            end
            StWrite: begin
                if (bus_grant) begin
                    if (last) begin
                        state_d = StDone;
                    end else begin
                        state_d = fill_mode ? StWrite : StRead;
                    end
                end else begin
                    state_d  = StReq;
                    resume_d = StWrite;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            resume_q <= StRead;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            data_q   <= data_d;
        end
    end

    // Bus is held from REQ through the last WRITE, never released between bytes.
    assign busy     = (state_q == StReq) || (state_q == StRead) || (state_q == StWrite);
    assign bus_req  = busy;
    assign done     = (state_q == StDone);
    assign write    = wr_fire;
    assign data_out = wr_fire ? data_q : '0;
    assign address  = rd_fire ? src_ptr : (wr_fire ? dst_ptr : '0);

endmodule

// File: tb/tb_bus_copy_engine.sv
`timescale 1ns/1ps
module tb_bus_copy_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] src_addr = 8'h0;
    logic [7:0] dst_addr = 8'h0;
    logic [7:0] count = 8'h0;
    logic       busy, done, bus_req, write;
    logic       bus_grant = 1'b0;
    logic [7:0] address, data_in, data_out;
    logic       fill = 1'b0;
    logic [7:0] fill_value = 8'h0;

    logic [7:0] ram [256];
    logic [7:0] exp_ram [256];
    logic       seed_ram = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_copy_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .bus_req    (bus_req),
        .bus_grant  (bus_grant),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .write      (write)
`ifdef BUS_COPY_FILL_EN
        ,
        .fill       (fill),
        .fill_value (fill_value)
`endif
    );

    // Bus responder: 256-byte RAM, combinational read, posedge write.
    assign data_in = ram[address];
    always @(posedge clk) begin
        if (seed_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'($urandom);
        end else if (write) begin
            ram[address] <= data_out;
        end
    end

    // Bus monitor, sampled mid-cycle.
    logic [7:0] wr_a [$];
    logic [7:0] wr_d [$];
    int mon_done = 0, mon_busy = 0, mon_req = 0, mon_bad = 0;
    always @(negedge clk) begin
        if (done) mon_done++;
        if (busy) mon_busy++;
        if (bus_req) mon_req++;
        if (write) begin
            wr_a.push_back(address);
            wr_d.push_back(data_out);
        end
        if (!bus_grant && (address != 8'h0 || write)) mon_bad++;
        if (write && !bus_req) mon_bad++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [7:0] cnt;
        bit         fil;
        logic [7:0] fv;
        int         mode;      // 0 grant tied 1, 1 random grant, 2 drop during 2nd READ
        bit         poke;      // extra start pulse while busy
        int         exp_busy;  // -1 = not checked
        int         exp_done;  // cycle of done relative to start, -1 = not checked
    } vec_t;

    vec_t vecs [$];

    function automatic bit grant_for(input int mode, input int c);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2) return !(c >= 4 && c <= 6);
        return 1'b1;
    endfunction

    function automatic vec_t mk(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                                input bit f, input logic [7:0] fv, input int mode,
                                input bit poke, input int eb, input int ed);
        vec_t v;
        v.src = s; v.dst = d; v.cnt = n; v.fil = f; v.fv = fv; v.mode = mode;
        v.poke = poke; v.exp_busy = eb; v.exp_done = ed;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] ea [$];
        logic [7:0] ed [$];
        logic [7:0] s, d;
        int done_cyc, busy0, done0, req0, bad0, bad_wr, bad_ram, c;
        for (int i = 0; i < 256; i++) exp_ram[i] = ram[i];
        // Forward byte-by-byte copy with 8-bit wrap.
        for (int i = 0; i < int'(v.cnt); i++) begin
            s = v.src + 8'(i);
            d = v.dst + 8'(i);
            exp_ram[d] = v.fil ? v.fv : exp_ram[s];
            ea.push_back(d);
            ed.push_back(exp_ram[d]);
        end
        wr_a.delete();
        wr_d.delete();
        busy0 = mon_busy; done0 = mon_done; req0 = mon_req; bad0 = mon_bad;
        done_cyc = -1;
        c = 0;
        while (c < 400 && (done_cyc < 0 || c < done_cyc + 3)) begin
            bus_grant = grant_for(v.mode, c);
            if (c == 0) begin
                start = 1'b1; src_addr = v.src; dst_addr = v.dst; count = v.cnt;
                fill = v.fil; fill_value = v.fv;
            end else begin
                start = v.poke && (c == 3);
                src_addr = 8'($urandom); dst_addr = 8'($urandom);
                count = 8'($urandom_range(1, 255));
                fill = 1'($urandom); fill_value = 8'($urandom);
            end
            @(negedge clk);
            if (done && done_cyc < 0) done_cyc = c;
            step();
            c++;
        end
        start = 1'b0;
        bus_grant = 1'b1;
        check({tag, " done_seen"}, 64'(done_cyc >= 0), 64'd1);
        check({tag, " done_pulses"}, 64'(mon_done - done0), 64'd1);
        if (v.exp_busy >= 0) check({tag, " busy_cycles"}, 64'(mon_busy - busy0), 64'(v.exp_busy));
        if (v.exp_done >= 0) check({tag, " done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
        if (v.cnt == 8'd0) check({tag, " no_bus_req"}, 64'(mon_req - req0), 64'd0);
        check({tag, " write_count"}, 64'(wr_a.size()), 64'(v.cnt));
        bad_wr = 0;
        for (int i = 0; i < ea.size() && i < wr_a.size(); i++) begin
            if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i]) bad_wr++;
        end
        check({tag, " write_sequence_errors"}, 64'(bad_wr), 64'd0);
        bad_ram = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) bad_ram++;
        check({tag, " ram_mismatches"}, 64'(bad_ram), 64'd0);
        check({tag, " bus_idle_when_ungranted"}, 64'(mon_bad - bad0), 64'd0);
    endtask

    task automatic reset_mid_copy();
        int done0, bad_ram;
        for (int i = 0; i < 256; i++) exp_ram[i] = ram[i];
        exp_ram[8'h60] = ram[8'h50];
        wr_a.delete();
        wr_d.delete();
        done0 = mon_done;
        bus_grant = 1'b1;
        for (int c = 0; c < 5; c++) begin
            start = (c == 0); src_addr = 8'h50; dst_addr = 8'h60; count = 8'd4;
            fill = 1'b0;
            step();
        end
        start = 1'b0;
        // Cycle 5 is the WRITE of byte 2.
        check("rst_pre_write", 64'({write, address}), 64'({1'b1, 8'h61}));
        reset = 1'b0;
        #1;
        check("rst_outputs_zero", 64'({busy, done, bus_req, address, data_out, write}), 64'd0);
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        check("rst_no_done", 64'(mon_done - done0), 64'd0);
        check("rst_write_count", 64'(wr_a.size()), 64'd1);
        bad_ram = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) bad_ram++;
        check("rst_ram_mismatches", 64'(bad_ram), 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        seed_ram = 1'b1;
        repeat (2) step();
        seed_ram = 1'b0;
        check("reset_outputs", 64'({busy, done, bus_req, address, data_out, write}), 64'd0);
        reset = 1'b1;
        step();

        vecs.push_back(mk(8'h80, 8'h10, 8'd4, 1'b0, 8'h00, 0, 1'b1, 9, 10));
        vecs.push_back(mk(8'h33, 8'h44, 8'd0, 1'b0, 8'h00, 0, 1'b0, 0, 1));
        vecs.push_back(mk(8'hFE, 8'hFF, 8'd3, 1'b0, 8'h00, 0, 1'b0, 7, 8));
        vecs.push_back(mk(8'h40, 8'h42, 8'd6, 1'b0, 8'h00, 0, 1'b0, 13, 14));
        vecs.push_back(mk(8'h80, 8'h10, 8'd4, 1'b0, 8'h00, 2, 1'b0, 13, 14));
`ifdef BUS_COPY_FILL_EN
        vecs.push_back(mk(8'h00, 8'h20, 8'd3, 1'b1, 8'hA5, 0, 1'b1, 4, 5));
        vecs.push_back(mk(8'h00, 8'hFE, 8'd4, 1'b1, 8'h3C, 1, 1'b1, -1, -1));
`endif
        foreach (vecs[i]) begin
            if (i == 4) begin
                // Scramble memory so the grant-drop copy must really move data.
                seed_ram = 1'b1;
                step();
                seed_ram = 1'b0;
            end
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        reset_mid_copy();
        run_vec(mk(8'h50, 8'h60, 8'd4, 1'b0, 8'h00, 0, 1'b0, 9, 10), "after_reset");

        for (int r = 0; r < 30; r++) begin
            vec_t v;
            n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
            v = mk(8'($urandom), 8'($urandom), 8'(n), 1'b0, 8'($urandom), 1, n >= 2, -1, -1);
`ifdef BUS_COPY_FILL_EN
            v.fil = 1'($urandom);
`endif
            run_vec(v, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
